divider_sm: RTL and testbench

- Sequential saturating sign-magnitude divider: Q = X / Y in the datapath's fixed-point sign-magnitude format.
- Companion to the combinational add/sub unit. It computes the gain-type quotients the filter datapath needs, e.g. P/(P+R).
- Restoring algorithm, one quotient bit per clock.
- Valid/ready handshake on both input and output sides.

---
 rtl/divider_sm.sv | 138 +++++++++++++
 tb/tb_divider_sm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/divider_sm.sv
// Sequential saturating sign-magnitude divider (restoring, one quotient bit per clock).
// Operands and quotient share one fixed-point format; handshakes on input and output.
module divider_sm #(
  parameter int W    = 24,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X_sm,
  input  logic [W-1:0] Y_sm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Q_sm,
  output logic         sat,
  output logic         div0
);

  localparam int ITER = W - 1 + FRAC;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [W-2:0] MAG_MAX = '1;

  logic [1:0]      state_q, state_d;
  logic            sign_q, sign_d;
  logic [W-2:0]    ymag_q, ymag_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [ITER-1:0] dvd_q, dvd_d;
  logic [ITER-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    q_q, q_d;
  logic            sat_q, sat_d;
  logic            div0_q, div0_d;

  logic [W:0]      shifted;
  logic            ge;
  logic [W-1:0]    diff;
  logic [W-2:0]    mag;

  // Trial subtraction; shifted[W] is always 0 in practice but keeps the compare exact.
  assign shifted = {rem_q, dvd_q[ITER-1]};
  assign ge      = (shifted >= {2'b00, ymag_q});
  assign diff    = shifted[W-1:0] - {1'b0, ymag_q};

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    ymag_d  = ymag_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sat_d   = sat_q;
    div0_d  = div0_q;
    mag     = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = X_sm[W-1] ^ Y_sm[W-1];
          ymag_d  = Y_sm[W-2:0];
          dvd_d   = {X_sm[W-2:0], {FRAC{1'b0}}};
          rem_d   = '0;
          quo_d   = '0;
          // A zero divisor skips the iterations and goes straight to result formation.
          cnt_d   = (Y_sm[W-2:0] == '0) ? '0 : CW'(ITER);
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (ymag_q == '0) begin
            mag    = MAG_MAX;
            sat_d  = 1'b0;
            div0_d = 1'b1;
          end else if (|quo_q[ITER-1:W-1]) begin
            mag    = MAG_MAX;
            sat_d  = 1'b1;
            div0_d = 1'b0;
          end else begin
            mag    = quo_q[W-2:0];
            sat_d  = 1'b0;
            div0_d = 1'b0;
          end
          q_d     = {sign_q & (|mag), mag};
          state_d = DONE;
        end else begin
          rem_d = ge ? diff : shifted[W-1:0];
          dvd_d = {dvd_q[ITER-2:0], 1'b0};
          quo_d = {quo_q[ITER-2:0], ge};
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ymag_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      sat_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      ymag_q  <= ymag_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sat_q   <= sat_d;
      div0_q  <= div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q_sm      = q_q;
  assign sat       = sat_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_divider_sm.sv
// Directed bench for divider_sm: hand-computed quotients, latency, backpressure, reset abort.
module tb_divider_sm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] X_sm;
  logic [23:0] Y_sm;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] Q_sm;
  logic        sat;
  logic        div0;

  int checks = 0;
  int errs   = 0;

  divider_sm #(.W(24), .FRAC(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X_sm      (X_sm),
    .Y_sm      (Y_sm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q_sm      (Q_sm),
    .sat       (sat),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then presents operands for exactly one accepting edge.
  task automatic applyStimulus(input logic [23:0] x, input logic [23:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    X_sm     = x;
    Y_sm     = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    X_sm     = 24'h5A5A5A;
    Y_sm     = 24'hA5A5A5;
  endtask

  task automatic waitOut(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
    checkOutput("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic runDivide(input string tag, input logic [23:0] x, input logic [23:0] y,
                           input logic [23:0] expQ, input logic expSat, input logic expDiv0,
                           input int expLat);
    int lat;
    applyStimulus(x, y);
    checkOutput({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    waitOut(lat);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_Q"}, {8'd0, Q_sm}, {8'd0, expQ});
    checkOutput({tag, "_sat"}, {31'd0, sat}, {31'd0, expSat});
    checkOutput({tag, "_div0"}, {31'd0, div0}, {31'd0, expDiv0});
    consume();
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X_sm      = '0;
    Y_sm      = '0;
    #12;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_Q", {8'd0, Q_sm}, 32'd0);
    checkOutput("reset_sat", {31'd0, sat}, 32'd0);
    checkOutput("reset_div0", {31'd0, div0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed divides");
    runDivide("basic",      24'h003000, 24'h001800, 24'h002000, 1'b0, 1'b0, 36);
    runDivide("neg_pos",    24'h801000, 24'h004000, 24'h800400, 1'b0, 1'b0, 36);
    runDivide("neg_neg",    24'h801000, 24'h804000, 24'h000400, 1'b0, 1'b0, 36);
    runDivide("sat_pos",    24'h7FFFFF, 24'h000001, 24'h7FFFFF, 1'b1, 1'b0, 36);
    runDivide("sat_neg",    24'hFFFFFF, 24'h000001, 24'hFFFFFF, 1'b1, 1'b0, 36);
    runDivide("truncate",   24'h000001, 24'h003000, 24'h000000, 1'b0, 1'b0, 36);
    runDivide("div0_pos0",  24'h801000, 24'h000000, 24'hFFFFFF, 1'b0, 1'b1, 1);
    runDivide("div0_neg0",  24'h001000, 24'h800000, 24'hFFFFFF, 1'b0, 1'b1, 1);
    runDivide("neg_zero_x", 24'h800000, 24'h001000, 24'h000000, 1'b0, 1'b0, 36);
    runDivide("frac",       24'h001000, 24'h003000, 24'h000555, 1'b0, 1'b0, 36);

    $display("[TB] backpressure");
    applyStimulus(24'h003000, 24'h801800);
    waitOut(lat);
    checkOutput("bp_latency", lat, 36);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      X_sm     = 24'h002000;
      Y_sm     = 24'h001000;
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_Q", {8'd0, Q_sm}, 32'h00802000);
      checkOutput("bp_sat", {31'd0, sat}, 32'd0);
      checkOutput("bp_div0", {31'd0, div0}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_no_queued_op", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] reset mid-operation");
    runDivide("pre_reset", 24'h7FFFFF, 24'h000001, 24'h7FFFFF, 1'b1, 1'b0, 36);
    applyStimulus(24'h003000, 24'h001800);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_Q", {8'd0, Q_sm}, 32'd0);
    checkOutput("rst_sat", {31'd0, sat}, 32'd0);
    checkOutput("rst_div0", {31'd0, div0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runDivide("post_reset", 24'h801000, 24'h004000, 24'h800400, 1'b0, 1'b0, 36);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
